// File: rtl/alu_result_fifo_pkg.sv
// Shared defaults and display constants for the ALU result queue.
package alu_result_fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Segment order a..g from MSB to LSB, active-low.
  localparam logic [6:0] BLANK_GLYPH = 7'b1111111;

endpackage

// File: rtl/hex_decoder.sv
// Nibble to 7-segment glyph, active-low, a..g from MSB to LSB.
// Purely combinational; no handshake.
module hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead queue of ALU results pushed by a button edge; head visible one cycle after push.
// No input backpressure: a push into a full queue is dropped and flagged unless a pop frees the slot.
module alu_result_fifo
  import alu_result_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             capture,
  input  logic             out_ready,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [6:0]       hex_lo,
  output logic [6:0]       hex_hi
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             capture_q;
  logic             push;
  logic             pop;
  logic             do_push;
  logic             drop;
  logic [6:0]       seg_lo;
  logic [6:0]       seg_hi;

  assign empty     = (count == 3'd0);
  assign full      = (count == DEPTH_C);
  assign out_valid = ~empty;

  assign push    = capture & ~capture_q;
  assign pop     = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 3'd0;
      overflow  <= 1'b0;
      capture_q <= 1'b1;
    end else begin
      capture_q <= capture;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= alu_result;
  end

  assign out_data = empty ? '0 : mem[rd_ptr];

  hex_decoder u_hex_lo (
    .nibble (out_data[3:0]),
    .seg    (seg_lo)
  );

  hex_decoder u_hex_hi (
    .nibble (out_data[7:4]),
    .seg    (seg_hi)
  );

  assign hex_lo = empty ? BLANK_GLYPH : seg_lo;
  assign hex_hi = empty ? BLANK_GLYPH : seg_hi;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed-vector bench for alu_result_fifo with hand-computed expectations.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_result;
  logic       capture;
  logic       out_ready;
  logic       clear_ovf;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [6:0] hex_lo;
  logic [6:0] hex_hi;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  alu_result_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .alu_result (alu_result),
    .capture    (capture),
    .out_ready  (out_ready),
    .clear_ovf  (clear_ovf),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .hex_lo     (hex_lo),
    .hex_hi     (hex_hi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; capture = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; alu_result = 8'h00;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [7:0] d);
    alu_result = d;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; capture = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; alu_result = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (count !== 3'd0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)     begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (hex_lo !== BLANK || hex_hi !== BLANK) begin failures++; $display("FAIL reset_hex got=%b/%b exp=%b", hex_hi, hex_lo, BLANK); end
  endtask

  task automatic test_first_push();
    apply_reset();
    alu_result = 8'h3C; capture = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL first_data got=%h exp=3c", out_data); end
    checks++; if (count !== 3'd1)     begin failures++; $display("FAIL first_count got=%0d exp=1", count); end
    checks++; if (hex_hi !== glyph[3])  begin failures++; $display("FAIL first_hex_hi got=%b exp=%b", hex_hi, glyph[3]); end
    checks++; if (hex_lo !== glyph[12]) begin failures++; $display("FAIL first_hex_lo got=%b exp=%b", hex_lo, glyph[12]); end
    capture = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    apply_reset();
    alu_result = 8'h55; capture = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", count); end
    capture = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d;
    apply_reset();
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    checks++; if (full !== 1'b1)      begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (count !== 3'd4)     begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (out_data !== 8'h01) begin failures++; $display("FAIL ovf_head got=%h exp=01", out_data); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_d = 8'(i);
      checks++; if (out_data !== exp_d) begin failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, out_data, exp_d); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain_empty got=%b/%b exp=1/0", empty, out_valid); end
    checks++; if (hex_lo !== BLANK || hex_hi !== BLANK) begin failures++; $display("FAIL ovf_drain_hex got=%b/%b exp=%b", hex_hi, hex_lo, BLANK); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'hAA};
    apply_reset();
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fpp_full got=%b exp=1", full); end
    alu_result = 8'hAA; capture = 1'b1; out_ready = 1'b1;
    tick();
    capture = 1'b0; out_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    checks++; if (count !== 3'd4)    begin failures++; $display("FAIL fpp_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_q[i]) begin failures++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, out_data, exp_q[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fpp_drain got=%0d exp=0", count); end
  endtask

  task automatic test_clear_ovf();
    apply_reset();
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_pre got=%b exp=1", overflow); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_cleared got=%b exp=0", overflow); end
    alu_result = 8'h66; capture = 1'b1; clear_ovf = 1'b1;
    tick();
    capture = 1'b0; clear_ovf = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%b exp=1", overflow); end
    checks++; if (count !== 3'd4 || out_data !== 8'h01) begin failures++; $display("FAIL clr_unchanged got=%0d/%h exp=4/01", count, out_data); end
  endtask

  task automatic test_reset_held();
    apply_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rh_pre got=%0d exp=3", count); end
    alu_result = 8'h77; capture = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rh_held got=%0d/%b exp=0/0", count, out_valid); end
    checks++; if (hex_lo !== BLANK || overflow !== 1'b0) begin failures++; $display("FAIL rh_flags got=%b/%b exp=%b/0", hex_lo, overflow, BLANK); end
    capture = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rh_fall got=%0d exp=0", count); end
    capture = 1'b1;
    tick();
    checks++; if (count !== 3'd1 || out_data !== 8'h77) begin failures++; $display("FAIL rh_repush got=%0d/%h exp=1/77", count, out_data); end
    capture = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    alu_result = 8'h11; capture = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd1 || out_data !== 8'h11) begin failures++; $display("FAIL b2b_empty_pp got=%0d/%h exp=1/11", count, out_data); end
    capture = 1'b0; out_ready = 1'b0;
    tick();
    alu_result = 8'h22; capture = 1'b1; out_ready = 1'b1;
    tick();
    capture = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd1 || out_data !== 8'h22) begin failures++; $display("FAIL b2b_mid_pp got=%0d/%h exp=1/22", count, out_data); end
    checks++; if (hex_hi !== glyph[2] || hex_lo !== glyph[2]) begin failures++; $display("FAIL b2b_hex got=%b/%b exp=%b", hex_hi, hex_lo, glyph[2]); end
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; alu_result = 8'h00;
    test_reset();
    test_first_push();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_clear_ovf();
    test_reset_held();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
